instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side master for the 32-bit instruction memory. The processor datapath is the read side of that memory.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one little-endian RISC-V instruction word.
- Writes each word through the memory's waddress/Datain/Wr port at consecutive word addresses.
- Holds the processor in reset while loading. Releases it once the programmed word count has been written.

Parameters:
- BASE_ADDR, 64'd0, byte address of the first word written.
- NUM_WORDS, 64, number of 32-bit words per load; legal range 1..4096.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a load; sampled in IDLE and DONE only.
- ABORT  in  1  synchronous cancel; returns to IDLE.
- BYTE_IN  in  8  stream byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- MEM_WADDR  out  64  write byte address to instruction memory.
- MEM_DATAIN  out  32  write data to instruction memory.
- MEM_WR  out  1  write strobe, one cycle per word.
- HOLD_CPU  out  1  drives processor reset while loading.
- BUSY  out  1  load in progress.
- DONE  out  1  load completed; sticky until next START or RST.
- WORD_COUNT  out  13  words written in the current load.

Behaviour:
- RST asserted, at any time including mid-load:
  - State IDLE.
  - BYTE_READY=0, MEM_WR=0, MEM_WADDR=BASE_ADDR, MEM_DATAIN=0.
  - HOLD_CPU=1, BUSY=0, DONE=0, WORD_COUNT=0.
  - Byte index and word buffer cleared.
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - HOLD_CPU=1, BUSY=0.
  - START=1 -> COLLECT; addr=BASE_ADDR, byte_idx=0, WORD_COUNT=0, DONE=0.
- COLLECT:
  - BUSY=1, HOLD_CPU=1, BYTE_READY=1 (combinational from state).
  - A transfer occurs on a rising edge with BYTE_VALID & BYTE_READY.
  - Byte k (k=0..3) stored in buffer bits [8k+7:8k]; byte_idx increments.
  - Transfer of byte 3 -> WRITE; byte_idx wraps to 0.
  - BYTE_VALID=0: state and buffer unchanged, no timeout.
- WRITE (exactly one cycle):
  - MEM_WR=1, MEM_WADDR=addr, MEM_DATAIN=buffer; BYTE_READY=0.
  - On exit: WORD_COUNT+1.
  - If new WORD_COUNT==NUM_WORDS -> FINISH.
  - Else addr+=4 (mod 2^64) -> COLLECT.
- MEM_WR is registered. The write cycle is the cycle immediately after the 4th byte handshake.
- Minimum 5 cycles per word: 4 accept cycles plus 1 write cycle.
- MEM_WADDR and MEM_DATAIN hold their last written values outside WRITE.
- FINISH:
  - DONE=1, BUSY=0, HOLD_CPU=0 (registered; processor leaves reset the cycle after entry).
  - START=1 -> COLLECT with a fresh load (same init as IDLE); HOLD_CPU=1 again the next cycle.
- ABORT:
  - Valid in any state; next state IDLE; buffer, byte_idx and WORD_COUNT cleared; DONE=0.
  - ABORT during WRITE suppresses MEM_WR that cycle (MEM_WR = write state & ~ABORT).
  - No partial word is ever written.
- START while BUSY: ignored. START and ABORT in the same cycle: ABORT wins.
- BYTE_VALID in IDLE, WRITE or FINISH: not accepted, because BYTE_READY=0; the source must hold the byte.
- NUM_WORDS=1: FINISH follows the first WRITE.

Test Plan:
- Reset then START. Stream 0x13,0x05,0x50,0x00 with VALID held high -> one MEM_WR pulse in the cycle after the 4th byte; MEM_WADDR=0, MEM_DATAIN=0x00500513; WORD_COUNT=1.
- NUM_WORDS=4, BASE_ADDR=0x100, 16 bytes streamed:
  - Writes occur at 0x100, 0x104, 0x108, 0x10C.
  - DONE=1 and HOLD_CPU=0 one cycle after the last write; BUSY=0.
  - Exactly 4 MEM_WR pulses in total.
- Random VALID gaps (e.g. VALID high 1 in 3 cycles) over 8 words -> same data and addresses as the gap-free run; no byte lost or duplicated; BYTE_READY low during every WRITE cycle.
- ABORT asserted in the WRITE cycle of word 2 -> no MEM_WR that cycle; state IDLE; WORD_COUNT=0.
  - A subsequent START restarts at BASE_ADDR.
- RST pulsed asynchronously mid-COLLECT after 2 bytes -> outputs take reset values immediately, without waiting for a clock edge.
  - The next load's first word contains only the new bytes.
- In FINISH, assert START and ABORT together -> IDLE, DONE=0.
  - Then START alone -> COLLECT, HOLD_CPU=1, DONE=0, WORD_COUNT=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction-memory write master: packs a little-endian byte stream into 32-bit
// words, writes them at consecutive addresses, and holds the CPU in reset until done.
//
// state   | meaning
// IDLE    | no load in progress, CPU held in reset
// COLLECT | accepting stream bytes into the word buffer
// WRITE   | one-cycle memory write of the assembled word
// FINISH  | load complete, CPU released, DONE sticky
module instr_mem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          NUM_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [63:0] MEM_WADDR,
  output logic [31:0] MEM_DATAIN,
  output logic        MEM_WR,
  output logic        HOLD_CPU,
  output logic        BUSY,
  output logic        DONE,
  output logic [12:0] WORD_COUNT
);

  localparam logic [12:0] LAST_COUNT = 13'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [23:0] buf_q, buf_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [12:0] wcount_q, wcount_d;
  logic [63:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    byte_idx_d = byte_idx_q;
    wcount_d   = wcount_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          state_d    = COLLECT;
          addr_d     = BASE_ADDR;
          byte_idx_d = 2'd0;
          wcount_d   = 13'd0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
        end
      end
      COLLECT: begin
        if (BYTE_VALID) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: buf_d[7:0]   = BYTE_IN;
            2'd1: buf_d[15:8]  = BYTE_IN;
            2'd2: buf_d[23:16] = BYTE_IN;
            default: begin
              // the last byte goes straight into the write register, bypassing the buffer
              waddr_d = addr_q;
              wdata_d = {BYTE_IN, buf_q};
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        wcount_d = wcount_q + 13'd1;
        if (wcount_q + 13'd1 == LAST_COUNT) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
        end else begin
          addr_d  = addr_q + 64'd4;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ABORT) begin
      state_d    = IDLE;
      buf_d      = 24'd0;
      byte_idx_d = 2'd0;
      wcount_d   = 13'd0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      hold_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      buf_q      <= 24'd0;
      byte_idx_q <= 2'd0;
      wcount_q   <= 13'd0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      byte_idx_q <= byte_idx_d;
      wcount_q   <= wcount_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // the write strobe is gated by ABORT so a cancelled word never reaches memory
  assign MEM_WR     = (state_q == WRITE) & ~ABORT;
  assign BYTE_READY = (state_q == COLLECT);
  assign MEM_WADDR  = waddr_q;
  assign MEM_DATAIN = wdata_q;
  assign HOLD_CPU   = hold_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign WORD_COUNT = wcount_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed byte streams, expected writes queued by the
// driver and checked by an independent write monitor.
module tb_instr_mem_loader;

  localparam logic [63:0] BASE = 64'h100;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [7:0]  BYTE_IN = 8'd0;
  logic        BYTE_VALID = 1'b0;

  logic        BYTE_READY, MEM_WR, HOLD_CPU, BUSY, DONE;
  logic [63:0] MEM_WADDR;
  logic [31:0] MEM_DATAIN;
  logic [12:0] WORD_COUNT;

  logic        ready_1, wr_1, hold_1, busy_1, done_1;
  logic [63:0] waddr_1;
  logic [31:0] datain_1;
  logic [12:0] wc_1;

  instr_mem_loader #(.BASE_ADDR(BASE), .NUM_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .MEM_WADDR(MEM_WADDR), .MEM_DATAIN(MEM_DATAIN), .MEM_WR(MEM_WR),
    .HOLD_CPU(HOLD_CPU), .BUSY(BUSY), .DONE(DONE), .WORD_COUNT(WORD_COUNT)
  );

  // single-word loader sharing the stream, for the NUM_WORDS=1 boundary
  instr_mem_loader #(.BASE_ADDR(64'd0), .NUM_WORDS(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(ready_1),
    .MEM_WADDR(waddr_1), .MEM_DATAIN(datain_1), .MEM_WR(wr_1),
    .HOLD_CPU(hold_1), .BUSY(busy_1), .DONE(done_1), .WORD_COUNT(wc_1)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          wr_pulses = 0;
  int          wr1_cnt = 0;
  logic [63:0] wr1_addr = 64'd0;
  logic [31:0] wr1_data = 32'd0;
  logic [31:0] prog [0:11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MEM_WR) begin
      wr_pulses++;
      check("ready_low_in_write", 64'(BYTE_READY), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", MEM_WADDR, MEM_DATAIN);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", MEM_WADDR, mon_e.addr);
        check("wr_data", 64'(MEM_DATAIN), 64'(mon_e.data));
      end
    end
    if (wr_1) begin
      wr1_cnt++;
      wr1_addr = waddr_1;
      wr1_data = datain_1;
    end
  end

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge CLK);
      if (BYTE_READY) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=0 expected=1");
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      BYTE_VALID = 1'b0;
      repeat (gap) @(posedge CLK);
      #1;
    end
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    wait_ready();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [63:0] addr,
                           input bit expect_wr, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    if (expect_wr) exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic run_load(input int first, input int gap);
    pulse_start();
    check("start_busy", 64'(BUSY), 64'd1);
    check("start_hold", 64'(HOLD_CPU), 64'd1);
    check("start_done", 64'(DONE), 64'd0);
    check("start_wc", 64'(WORD_COUNT), 64'd0);
    for (int i = 0; i < 4; i++) send_word(prog[first+i], BASE + 64'(4*i), 1'b1, gap);
    BYTE_VALID = 1'b0;
    @(posedge CLK);
    #1;
    check("fin_done", 64'(DONE), 64'd1);
    check("fin_hold", 64'(HOLD_CPU), 64'd0);
    check("fin_busy", 64'(BUSY), 64'd0);
    check("fin_wc", 64'(WORD_COUNT), 64'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    prog[0]  = 32'h00500513; prog[1]  = 32'h00a00593;
    prog[2]  = 32'h00b50633; prog[3]  = 32'h0000006f;
    prog[4]  = 32'hdeadbeef; prog[5]  = 32'h12345678;
    prog[6]  = 32'h80000001; prog[7]  = 32'h0f0f0f0f;
    prog[8]  = 32'h00000073; prog[9]  = 32'h00100093;
    prog[10] = 32'h00208113; prog[11] = 32'hfe000ee3;

    // reset values, before any clock edge
    #1 RST = 1'b1;
    #2;
    check("rst_ready", 64'(BYTE_READY), 64'd0);
    check("rst_wr", 64'(MEM_WR), 64'd0);
    check("rst_waddr", MEM_WADDR, BASE);
    check("rst_datain", 64'(MEM_DATAIN), 64'd0);
    check("rst_hold", 64'(HOLD_CPU), 64'd1);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_wc", 64'(WORD_COUNT), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // gap-free load of four words, with a look at the first word's completion
    pulse_start();
    check("t1_busy", 64'(BUSY), 64'd1);
    send_word(prog[0], BASE, 1'b1, 0);
    @(posedge CLK);
    #1;
    check("t1_wc1", 64'(WORD_COUNT), 64'd1);
    check("t1_pulses1", 64'(wr_pulses), 64'd1);
    check("n1_done", 64'(done_1), 64'd1);
    check("n1_hold", 64'(hold_1), 64'd0);
    check("n1_wc", 64'(wc_1), 64'd1);
    check("n1_wrcnt", 64'(wr1_cnt), 64'd1);
    check("n1_addr", wr1_addr, 64'd0);
    check("n1_data", 64'(wr1_data), 64'h00500513);
    for (int i = 1; i < 4; i++) send_word(prog[i], BASE + 64'(4*i), 1'b1, 0);
    BYTE_VALID = 1'b0;
    check("t1_done_in_write", 64'(DONE), 64'd0);
    @(posedge CLK);
    #1;
    check("t1_done", 64'(DONE), 64'd1);
    check("t1_hold", 64'(HOLD_CPU), 64'd0);
    check("t1_busy_end", 64'(BUSY), 64'd0);
    check("t1_pulses", 64'(wr_pulses), 64'd4);

    // eight words with VALID high one cycle in three, restarting from FINISH
    run_load(0, 2);
    run_load(4, 2);
    check("t2_pulses", 64'(wr_pulses), 64'd12);

    // abort in the write cycle of word 2
    pulse_start();
    send_word(32'h11223344, BASE, 1'b1, 0);
    send_word(32'h55667788, BASE + 64'd4, 1'b0, 0);
    prev = wr_pulses;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    BYTE_VALID = 1'b0;
    check("ab_no_wr", 64'(wr_pulses), 64'(prev));
    check("ab_busy", 64'(BUSY), 64'd0);
    check("ab_wc", 64'(WORD_COUNT), 64'd0);
    check("ab_hold", 64'(HOLD_CPU), 64'd1);
    check("ab_done", 64'(DONE), 64'd0);
    check("ab_ready", 64'(BYTE_READY), 64'd0);
    pulse_start();
    send_word(32'hcafef00d, BASE, 1'b1, 0);
    BYTE_VALID = 1'b0;
    @(posedge CLK);
    #1;
    check("ab_restart_wc", 64'(WORD_COUNT), 64'd1);
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;

    // asynchronous reset after two bytes of a word
    pulse_start();
    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    #2 RST = 1'b1;
    #1;
    check("ar_ready", 64'(BYTE_READY), 64'd0);
    check("ar_busy", 64'(BUSY), 64'd0);
    check("ar_hold", 64'(HOLD_CPU), 64'd1);
    check("ar_datain", 64'(MEM_DATAIN), 64'd0);
    check("ar_waddr", MEM_WADDR, BASE);
    check("ar_wc", 64'(WORD_COUNT), 64'd0);
    BYTE_VALID = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    run_load(8, 0);

    // START and ABORT together in FINISH, then START alone
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    check("sa_busy", 64'(BUSY), 64'd0);
    check("sa_done", 64'(DONE), 64'd0);
    check("sa_hold", 64'(HOLD_CPU), 64'd1);
    check("sa_ready", 64'(BYTE_READY), 64'd0);
    pulse_start();
    check("rs_busy", 64'(BUSY), 64'd1);
    check("rs_hold", 64'(HOLD_CPU), 64'd1);
    check("rs_done", 64'(DONE), 64'd0);
    check("rs_wc", 64'(WORD_COUNT), 64'd0);
    check("rs_ready", 64'(BYTE_READY), 64'd1);
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    check("end_pending", 64'(exp_q.size()), 64'd0);
    check("end_pulses", 64'(wr_pulses), 64'd18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
